// File: rtl/rca_seq_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor controller.
// Holds the FSM state encoding and the adder slice width.
package rca_seq_ctrl_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rca_seq_ctrl_if.sv
// Operand-in / result-out handshake bundle for rca_seq_ctrl.
// The master is the producer/consumer side; the slave is the controller.
interface rca_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             SUB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             OVF;

    modport master (
        output in_valid, A, B, Cin, SUB, out_ready,
        input  in_ready, out_valid, S, Cout, OVF
    );

    modport slave (
        input  in_valid, A, B, Cin, SUB, out_ready,
        output in_ready, out_valid, S, Cout, OVF
    );
endinterface

// File: rtl/rca_seq_ctrl_add4_slice.sv
// Combinational 4-bit ripple-carry adder built from four chained full adders.
// This is the single arithmetic slice that the controller time-shares.
module add4_slice
    import rca_seq_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               cin_i,
    output logic [SLICE_W-1:0] sum_o,
    output logic               cout_o
);

    logic [SLICE_W:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = carry[SLICE_W];

endmodule

// File: rtl/rca_seq_ctrl.sv
// Multi-cycle WIDTH-bit adder/subtractor: one nibble per cycle, LSB first,
// through a shared 4-bit slice with the carry held in a register between passes.
module rca_seq_ctrl
    import rca_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    rca_seq_ctrl_if.slave  bus
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int KW     = $clog2(NSLICE);

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [SLICE_W-1:0] sliceA;
    logic [SLICE_W-1:0] sliceB;
    logic [SLICE_W-1:0] sliceSum;
    logic               sliceCout;

    assign sliceA = opA_q[k_q*SLICE_W +: SLICE_W];
    assign sliceB = opB_q[k_q*SLICE_W +: SLICE_W];

    add4_slice u_slice (
        .a_i    (sliceA),
        .b_i    (sliceB),
        .cin_i  (carry_q),
        .sum_o  (sliceSum),
        .cout_o (sliceCout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            opA_q   <= '0;
            opB_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Subtraction is folded into the operands at accept: invert B and force carry-in to 1.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        carry_d = carry_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    opA_d   = bus.A;
                    opB_d   = bus.SUB ? ~bus.B : bus.B;
                    carry_d = bus.SUB ? 1'b1 : bus.Cin;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[k_q*SLICE_W +: SLICE_W] = sliceSum;
                carry_d = sliceCout;
                if (k_q == KW'(NSLICE - 1)) begin
                    cout_d  = sliceCout;
                    ovf_d   = (opA_q[WIDTH-1] == opB_q[WIDTH-1]) &&
                              (sliceSum[SLICE_W-1] != opA_q[WIDTH-1]);
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.S         = s_q;
    assign bus.Cout      = cout_q;
    assign bus.OVF       = ovf_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Randomized self-checking bench for rca_seq_ctrl (WIDTH=16) against an
// integer-arithmetic reference model, plus directed corner cases.
module tb_rca_seq_ctrl;

    localparam int WIDTH = 16;

    logic clk;
    logic rst;
    int   assertCount;
    int   failCount;

    rca_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    rca_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: plain two's-complement arithmetic on the original operands.
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sub, output logic [15:0] s, output logic cout,
                         output logic ovf);
        int unsigned u;
        int          sres;
        if (sub) begin
            u    = int'(a) - int'(b);
            cout = (a >= b);
            sres = int'($signed(a)) - int'($signed(b));
        end else begin
            u    = int'(a) + int'(b) + int'(cin);
            cout = (u >= 32'd65536);
            sres = int'($signed(a)) + int'($signed(b)) + int'(cin);
        end
        s   = u[15:0];
        ovf = (sres > 32767) || (sres < -32768);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, latency check, optional backpressure, handoff.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub, input int hold);
        logic [15:0] expS;
        logic        expC;
        logic        expO;
        int          n;
        model(a, b, cin, sub, expS, expC, expO);

        n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        checkOutput("in_ready_before_accept", 32'(bus.in_ready), 32'd1);

        bus.A        = a;
        bus.B        = b;
        bus.Cin      = cin;
        bus.SUB      = sub;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.A        = 16'($urandom);
        bus.B        = 16'($urandom);
        bus.Cin      = 1'($urandom);
        bus.SUB      = 1'($urandom);
        checkOutput("in_ready_in_run", 32'(bus.in_ready), 32'd0);

        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        checkOutput("latency", 32'(n), 32'd4);
        if (!bus.out_valid) return;

        checkOutput("S", 32'(bus.S), 32'(expS));
        checkOutput("Cout", 32'(bus.Cout), 32'(expC));
        checkOutput("OVF", 32'(bus.OVF), 32'(expO));

        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            tick();
            checkOutput("hold_out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("hold_in_ready", 32'(bus.in_ready), 32'd0);
            checkOutput("hold_S", 32'(bus.S), 32'(expS));
            checkOutput("hold_Cout", 32'(bus.Cout), 32'(expC));
            checkOutput("hold_OVF", 32'(bus.OVF), 32'(expO));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checkOutput("idle_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("idle_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("idle_S_held", 32'(bus.S), 32'(expS));
    endtask

    initial begin
        assertCount   = 0;
        failCount     = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.Cin       = 1'b0;
        bus.SUB       = 1'b0;

        repeat (2) tick();
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_S", 32'(bus.S), 32'd0);
        checkOutput("rst_Cout", 32'(bus.Cout), 32'd0);
        checkOutput("rst_OVF", 32'(bus.OVF), 32'd0);
        rst = 1'b0;
        tick();

        applyStimulus(16'h1234, 16'h0FED, 1'b0, 1'b0, 0);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        applyStimulus(16'h0007, 16'h0005, 1'b0, 1'b1, 1);
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1, 3);
        applyStimulus(16'h7FFF, 16'h0000, 1'b1, 1'b0, 0);
        applyStimulus(16'h1234, 16'h1234, 1'b1, 1'b1, 0);

        // Abort in the middle of RUN: outputs must clear before the next edge.
        bus.A        = 16'hABCD;
        bus.B        = 16'h1111;
        bus.SUB      = 1'b0;
        bus.Cin      = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("abort_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("abort_S", 32'(bus.S), 32'd0);
        checkOutput("abort_Cout", 32'(bus.Cout), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        applyStimulus(16'hABCD, 16'h1111, 1'b1, 1'b0, 0);

        for (int i = 0; i < 60; i++) begin
            applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                          int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
